// File: rtl/edge_row_packer_pkg.sv
// Shared definitions for the edge-detection chip and its row packer.
// IMG_DIM     : pixels per row and rows per frame.
// BIT_LENGTH  : pixel width on the chip's input side.
// ROW_W       : width of the row/column counters (2^ROW_W >= IMG_DIM).
// FIFO_DEPTH  : default number of buffered row words.
// row_entry_t : one buffered row, {row index, packed edge bits}.
package edge_row_packer_pkg;

  localparam int IMG_DIM    = 20;
  localparam int BIT_LENGTH = 8;
  localparam int ROW_W      = 5;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic [ROW_W-1:0]   row_idx;
    logic [IMG_DIM-1:0] data;
  } row_entry_t;

endpackage

// File: rtl/edge_row_fifo.sv
// Synchronous FIFO with a registered head.
// Ports: clk/reset (async, active-high); push/din write an entry; pop removes
// the head; dout shows the head (holds its last value while empty);
// full/empty/count report occupancy. A push while full is ignored unless a
// pop happens in the same cycle.
module edge_row_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg, rd_ptr_next, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             do_push, do_pop;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

  always_comb begin
    do_pop      = pop & ~empty;
    do_push     = push & (~full | do_pop);
    rd_ptr_next = do_pop  ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
    wr_ptr_next = do_push ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
    count_next  = count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Storage has no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // The head register is loaded with whatever entry sits at the new read
  // pointer. If that slot is being written this very cycle (queue drains to
  // empty and refills), take the incoming word directly. When the queue
  // becomes empty the head keeps its last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      dout       <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      if (count_next != '0) begin
        dout <= (do_push && (wr_ptr_reg == rd_ptr_next)) ? din : mem[rd_ptr_next];
      end
    end
  end

endmodule

// File: rtl/edge_row_packer.sv
// Packs the edge chip's serial bit stream into row words and hands them to a
// row-wide sink over valid/ready.
// Ports: clk, reset (async, active-high); edge_in/edge_valid from the chip
// (never stalled); row_ready from the sink; row_data/row_idx/row_valid present
// the oldest buffered row; frame_done pulses one cycle after the last row of a
// frame is popped; overflow is sticky once a completed row has been dropped.
module edge_row_packer #(
  parameter int IMG_DIM    = edge_row_packer_pkg::IMG_DIM,
  parameter int FIFO_DEPTH = edge_row_packer_pkg::FIFO_DEPTH,
  parameter int ROW_W      = edge_row_packer_pkg::ROW_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               edge_in,
  input  logic               edge_valid,
  input  logic               row_ready,
  output logic [IMG_DIM-1:0] row_data,
  output logic               row_valid,
  output logic [ROW_W-1:0]   row_idx,
  output logic               frame_done,
  output logic               overflow
);

  localparam int FW    = ROW_W + IMG_DIM;
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  logic [ROW_W-1:0]   col_reg, row_reg;
  logic [IMG_DIM-1:0] shift_reg, word_next;
  logic               overflow_reg, frame_done_reg;
  logic               row_end, pop, fifo_full, fifo_empty;
  logic [FW-1:0]      fifo_head;
  logic [CNT_W-1:0]   fifo_count;

  // Word including the bit being accepted this cycle, so the row pushed on
  // its last column already contains that column.
  always_comb begin
    word_next          = shift_reg;
    word_next[col_reg] = edge_in;
  end

  assign row_end   = edge_valid && (col_reg == ROW_W'(IMG_DIM-1));
  assign row_valid = (fifo_count != '0);
  assign pop       = row_ready & ~fifo_empty;
  assign row_idx   = fifo_head[FW-1 -: ROW_W];
  assign row_data  = fifo_head[IMG_DIM-1:0];
  assign overflow   = overflow_reg;
  assign frame_done = frame_done_reg;

  edge_row_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (row_end),
    .pop   (pop),
    .din   ({row_reg, word_next}),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_reg        <= '0;
      row_reg        <= '0;
      shift_reg      <= '0;
      overflow_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      if (edge_valid) begin
        shift_reg <= word_next;
        if (row_end) begin
          col_reg <= '0;
          // Row index advances even if the word is dropped, so later rows
          // keep their true position in the frame.
          row_reg <= (row_reg == ROW_W'(IMG_DIM-1)) ? '0 : row_reg + ROW_W'(1);
        end else begin
          col_reg <= col_reg + ROW_W'(1);
        end
      end
      if (row_end && fifo_full && !pop) begin
        overflow_reg <= 1'b1;
      end
      frame_done_reg <= pop && (row_idx == ROW_W'(IMG_DIM-1));
    end
  end

endmodule

// File: tb/tb_edge_row_packer.sv
// Directed bench for edge_row_packer with a scoreboard queue of expected rows.
module tb_edge_row_packer;
  import edge_row_packer_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               edge_in = 1'b0;
  logic               edge_valid = 1'b0;
  logic               row_ready = 1'b0;
  logic [IMG_DIM-1:0] row_data;
  logic               row_valid;
  logic [ROW_W-1:0]   row_idx;
  logic               frame_done;
  logic               overflow;

  always #5 clk = ~clk;

  edge_row_packer #(
    .IMG_DIM    (IMG_DIM),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ROW_W      (ROW_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .edge_in    (edge_in),
    .edge_valid (edge_valid),
    .row_ready  (row_ready),
    .row_data   (row_data),
    .row_valid  (row_valid),
    .row_idx    (row_idx),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  row_entry_t         exp_q[$];
  int                 m_col, m_row;
  logic [IMG_DIM-1:0] m_word;
  logic               exp_ovf, exp_fd, all_ones;
  int                 total, bad, pops, fd_seen;
  int                 first_pop_idx, last_pop_idx;
  logic [IMG_DIM-1:0] got_data [IMG_DIM];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    m_col   = 0;
    m_row   = 0;
    m_word  = '0;
    exp_ovf = 1'b0;
    exp_fd  = 1'b0;
  endtask

  // One clock: drive inputs at the falling edge, check the state the previous
  // rising edge produced, then advance the model for the coming rising edge.
  task automatic step(input logic ev, input logic rdy);
    row_entry_t e;
    logic       b, pop_now, full_before;
    @(negedge clk);
    b          = all_ones ? 1'b1 : 1'((m_row + m_col) % 2);
    edge_valid = ev;
    edge_in    = b;
    row_ready  = rdy;
    chk("row_valid", 32'(row_valid), 32'(exp_q.size() != 0));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("frame_done", 32'(frame_done), 32'(exp_fd));
    if (frame_done) fd_seen++;
    full_before = (exp_q.size() == FIFO_DEPTH);
    pop_now     = rdy && (exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("row_idx", 32'(row_idx), 32'(exp_q[0].row_idx));
      chk("row_data", 32'(row_data), 32'(exp_q[0].data));
    end
    exp_fd = 1'b0;
    if (pop_now) begin
      e = exp_q.pop_front();
      pops++;
      if (pops == 1) first_pop_idx = int'(row_idx);
      last_pop_idx = int'(row_idx);
      got_data[e.row_idx] = row_data;
      exp_fd = (e.row_idx == ROW_W'(IMG_DIM-1));
      $display("pop row_idx=%0d data=%05h", row_idx, row_data);
    end
    if (ev) begin
      m_word[m_col] = b;
      if (m_col == IMG_DIM-1) begin
        if (full_before && !pop_now) exp_ovf = 1'b1;
        else exp_q.push_back('{row_idx: ROW_W'(m_row), data: m_word});
        m_col = 0;
        m_row = (m_row == IMG_DIM-1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    edge_valid = 1'b0;
    row_ready  = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_row_data", 32'(row_data), 32'd0);
    chk("rst_row_valid", 32'(row_valid), 32'd0);
    chk("rst_row_idx", 32'(row_idx), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    clear_model();
    @(negedge clk);
    reset = 1'b0;
    pops    = 0;
    fd_seen = 0;
  endtask

  initial begin
    total = 0; bad = 0; pops = 0; fd_seen = 0;
    first_pop_idx = -1; last_pop_idx = -1;
    all_ones = 1'b0;
    clear_model();

    // Continuous stream, sink always ready.
    do_reset();
    repeat (400) step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    chk("t1_pops", 32'(pops), 32'd20);
    chk("t1_frame_done_pulses", 32'(fd_seen), 32'd1);
    chk("t1_first_idx", 32'(first_pop_idx), 32'd0);
    chk("t1_last_idx", 32'(last_pop_idx), 32'd19);
    chk("t1_row0", 32'(got_data[0]), 32'h000AAAAA);
    chk("t1_row1", 32'(got_data[1]), 32'h00055555);

    // edge_valid toggling: same words, row_valid one cycle after last bit.
    pops = 0; fd_seen = 0;
    for (int i = 0; i < 800; i++) step(1'((i % 2) == 0), 1'b1);
    repeat (3) step(1'b0, 1'b1);
    chk("t2_pops", 32'(pops), 32'd20);
    chk("t2_frame_done_pulses", 32'(fd_seen), 32'd1);
    chk("t2_row0", 32'(got_data[0]), 32'h000AAAAA);
    chk("t2_row19", 32'(got_data[19]), 32'h00055555);

    // Stalled sink for 6 rows of ones: 4 buffered, 2 dropped.
    all_ones = 1'b1;
    repeat (120) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("t3_row_valid", 32'(row_valid), 32'd1);
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_row_data", 32'(row_data), 32'h000FFFFF);
    pops = 0;
    repeat (6) step(1'b0, 1'b1);
    chk("t3_pops", 32'(pops), 32'd4);
    chk("t3_first_idx", 32'(first_pop_idx), 32'd0);
    chk("t3_last_idx", 32'(last_pop_idx), 32'd3);
    all_ones = 1'b0;
    repeat (20) step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    chk("t3_next_row_idx", 32'(last_pop_idx), 32'd6);

    // Full FIFO, ready rises exactly as row 4 completes: nothing lost.
    do_reset();
    first_pop_idx = -1;
    all_ones = 1'b1;
    repeat (99) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    chk("t4_overflow", 32'(overflow), 32'd0);
    repeat (6) step(1'b0, 1'b1);
    chk("t4_pops", 32'(pops), 32'd5);
    chk("t4_first_idx", 32'(first_pop_idx), 32'd0);
    chk("t4_last_idx", 32'(last_pop_idx), 32'd4);
    all_ones = 1'b0;

    // Reset mid-row with two rows buffered, then a clean frame.
    do_reset();
    repeat (47) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("t5_buffered_valid", 32'(row_valid), 32'd1);
    do_reset();
    first_pop_idx = -1;
    repeat (400) step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    chk("t5_pops", 32'(pops), 32'd20);
    chk("t5_first_idx", 32'(first_pop_idx), 32'd0);
    chk("t5_row0", 32'(got_data[0]), 32'h000AAAAA);

    // Two back-to-back frames.
    pops = 0; fd_seen = 0;
    repeat (800) step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    chk("t6_pops", 32'(pops), 32'd40);
    chk("t6_frame_done_pulses", 32'(fd_seen), 32'd2);
    chk("t6_overflow", 32'(overflow), 32'd0);
    chk("t6_last_idx", 32'(last_pop_idx), 32'd19);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edge_row_packer.md
Name: edge_row_packer

Overview:
- Downstream consumer of the edge-detection chip's serial output. It samples `edge_out` whenever `readable` is high.
- It packs each image row of IMG_DIM edge bits into one word and buffers completed rows in a small FIFO.
- It presents rows to the host/memory side through a valid/ready handshake, tagged with a row index, and flags the end of each frame.
- It decouples the chip's one-bit-per-cycle output from a slower or stalling row-wide sink.

Parameters:
- IMG_DIM, 20, pixels per row and rows per frame.
- FIFO_DEPTH, 4, number of buffered row words (power of two, at least 2).
- ROW_W, 5, width of the row/column counters; must satisfy 2^ROW_W >= IMG_DIM.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- edge_in  input  1  edge bit from the chip (`edge_out`).
- edge_valid  input  1  qualifies edge_in (the chip's `readable`).
- row_ready  input  1  sink accepts the current row word.
- row_data  output  IMG_DIM  packed row; column c at bit c.
- row_valid  output  1  row_data/row_idx hold a valid row.
- row_idx  output  ROW_W  row number (0..IMG_DIM-1) of row_data.
- frame_done  output  1  one-cycle pulse when row IMG_DIM-1 is popped.
- overflow  output  1  sticky: a completed row was dropped because the FIFO was full.

Behaviour:
- Reset: one clock domain; reset is asynchronous and active-high. All outputs are 0 on reset: row_data, row_valid, row_idx, frame_done, overflow. Column counter, row counter, shift register and FIFO pointers/count clear to 0. Reset asserted mid-row or mid-frame discards all partial and buffered data; the next accepted bit is column 0 of row 0.
- Accept: a bit is accepted on every rising edge with edge_valid=1. There is no backpressure toward the chip; edge_valid is never stalled.
- Packing: the accepted bit is written to shift register bit [col], then col increments. When col = IMG_DIM-1 and the bit is accepted:
  - the complete word, including that bit, is pushed with the current row counter;
  - col wraps to 0;
  - row increments, wrapping from IMG_DIM-1 to 0 (next frame).
- Push latency: row_valid/row_data reflect a pushed word one cycle after its last bit is accepted, when the FIFO was empty.
- FIFO: entries are {row counter, word}. Head is shown on row_data/row_idx, with row_valid = (count != 0). Pop occurs when row_valid & row_ready at the clock edge.
- Full, push without simultaneous pop: the word is dropped and overflow is set, staying set until reset. The row counter still advances, so later rows keep correct indices.
- Full, push and pop in the same cycle: both occur and nothing is lost; count is unchanged.
- Empty FIFO with row_ready=1: no effect.
- Outputs while row_valid=0: row_data and row_idx hold their last value. Sinks must ignore them.
- frame_done: registered; asserted for exactly one cycle after the edge on which the entry with row_idx = IMG_DIM-1 is popped. It does not fire for a dropped row IMG_DIM-1.
- Stability: row_data and row_idx stay stable while row_valid=1 and row_ready=0.
- Pointers: wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- Structure: no combinational path from edge_in/edge_valid to any output. row_ready affects only the next state.

Decomposition:
- Shared package (shared with the chip): IMG_DIM and BIT_LENGTH. Also a row_entry struct/typedef of {row_idx[ROW_W], data[IMG_DIM]}.
- One sub-module: edge_row_fifo, a synchronous FIFO.
  - Parameters: WIDTH, DEPTH.
  - Ports: push/pop/full/empty/count.
  - Rule: push while full is ignored; simultaneous push+pop is allowed at full.
- The packer holds the column/row counters, shift register, overflow flag and frame_done logic.

Test Plan:
- Reset, then 400 bits with edge_valid=1 continuously and row_ready=1; bit = (row+col)&1 → 20 rows popped in order, row_idx 0..19, row 0 data = 0xAAAAA, row 1 = 0x55555, frame_done a single pulse after row 19, overflow=0.
- Same stream with edge_valid toggling 1,0,1,0 → identical row words and indices; first row_valid exactly one cycle after the 20th accepted bit.
- row_ready=0 for 6 complete rows (all bits 1) → rows 0..3 buffered with row_valid=1 and row_data=0xFFFFF; rows 4 and 5 dropped; overflow=1. Then row_ready=1 → indices 0,1,2,3 pop. The next row completed is tagged 6.
- FIFO full (4 rows) and row_ready asserted on the exact cycle row 4 completes → no drop, overflow stays 0, pops yield 0,1,2,3,4.
- Reset asserted after 7 bits of row 2 with 2 rows buffered → all outputs 0 immediately. A new 400-bit frame then yields row_idx starting at 0 with correct data.
- Two back-to-back frames (800 bits) → row_idx wraps 19→0, exactly two frame_done pulses, no overflow.
